// File: rtl/hex_entry_pkg.sv
// Shared definitions for the hex word entry block: data widths, FSM state
// encoding, the default debounce interval and the digit-load helper.
package hex_entry_pkg;

    localparam int DATA_W           = 15;
    localparam int DIGITS           = 4;
    localparam int DIGIT_W          = $clog2(DIGITS);
    // 10 ms at a 50 MHz system clock.
    localparam int DEBOUNCE_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_ENTRY      = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_WRITE      = 2'd2
    } state_t;

    // Replace one hex digit of the word under construction. The top digit
    // only has three bits of room, so nib[3] is dropped there.
    function automatic logic [DATA_W-1:0] load_digit(
        input logic [DATA_W-1:0]  word,
        input logic [DIGIT_W-1:0] pos,
        input logic [3:0]         nib
    );
        logic [DATA_W-1:0] r;
        r = word;
        case (pos)
            2'd3:    r[14:12] = nib[2:0];
            2'd2:    r[11:8]  = nib;
            2'd1:    r[7:4]   = nib;
            default: r[3:0]   = nib;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_entry_key_debounce.sv
// Raw active-low pushbutton conditioning: two-flop synchronizer, a
// run-length debouncer, and a single-cycle press pulse on an accepted 1->0
// transition. A press is only reported once the key has first been seen
// stably released, so a key held through reset stays silent until it is
// let go and pressed again. DEBOUNCE_CYCLES is expected to be >= 3 so the
// two reset-value synchronizer samples cannot arm a key that is held low.
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             sample;
    logic             cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    assign sample  = sync_q[1];
    assign press_o = press_q;

    // Run-length tracking of the synchronized sample and level acceptance.
    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        armed_d = armed_q;
        if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_MAX) begin
            level_d = cand_d;
            if (cand_d) begin
                armed_d = 1'b1;
            end
        end
        press_d = armed_q & level_q & ~level_d;
    end

    // Synchronizer, debouncer state and press pulse registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cand_q  <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Hex word entry: digits are dialled on the switches and loaded one at a
// time with the "next" key (most significant first); the "commit" key hands
// the assembled 15-bit word to a FIFO, waiting for space if it is full.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        sw,
    input  logic              key_next_n,
    input  logic              key_commit_n,
    input  logic              full,
    output logic [DATA_W-1:0] dataIn,
    output logic              write,
    output logic [DATA_W-1:0] preview,
    output logic [1:0]        digit_pos,
    output logic              pending
);

    localparam logic [DIGIT_W-1:0] TOP_DIGIT = DIGIT_W'(DIGITS - 1);

    logic next_ev;
    logic commit_ev;

    state_t             state_q,   state_d;
    logic [DATA_W-1:0]  preview_q, preview_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic [DIGIT_W-1:0] digit_q,   digit_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_next (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n_i(key_next_n),
        .press_o(next_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_commit (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n_i(key_commit_n),
        .press_o(commit_ev)
    );

    // Next-state logic: digit loading, commit handshake with the FIFO, and
    // the post-write clear. Commit takes priority over a same-cycle next;
    // key events outside ENTRY are simply dropped.
    always_comb begin
        state_d   = state_q;
        preview_d = preview_q;
        data_d    = data_q;
        digit_d   = digit_q;
        case (state_q)
            ST_ENTRY: begin
                if (commit_ev) begin
                    if (full) begin
                        state_d = ST_WAIT_SPACE;
                    end else begin
                        state_d = ST_WRITE;
                        data_d  = preview_q;
                    end
                end else if (next_ev) begin
                    preview_d = load_digit(preview_q, digit_q, sw);
                    digit_d   = digit_q - DIGIT_W'(1);
                end
            end
            ST_WAIT_SPACE: begin
                if (!full) begin
                    state_d = ST_WRITE;
                    data_d  = preview_q;
                end
            end
            ST_WRITE: begin
                state_d   = ST_ENTRY;
                preview_d = '0;
                digit_d   = TOP_DIGIT;
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    // State, word-under-construction and FIFO data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ENTRY;
            preview_q <= '0;
            data_q    <= '0;
            digit_q   <= TOP_DIGIT;
        end else begin
            state_q   <= state_d;
            preview_q <= preview_d;
            data_q    <= data_d;
            digit_q   <= digit_d;
        end
    end

    // The write strobe and pending flag are decoded straight from the state
    // register, so both are glitch-free and last exactly as long as the state.
    assign write     = (state_q == ST_WRITE);
    assign pending   = (state_q == ST_WAIT_SPACE);
    assign dataIn    = data_q;
    assign preview   = preview_q;
    assign digit_pos = digit_q;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with a short debounce interval. A small
// event-level model (word value, digit cursor, pending flag, list of words
// expected at the FIFO) is updated after each key action settles and is
// compared against the outputs every quiet cycle; a write monitor collects
// every strobe and polices the FIFO handshake rules.
module tb_hex_entry;

    localparam int DEB = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sw;
    logic        key_next_n;
    logic        key_commit_n;
    logic        full;
    logic [14:0] dataIn;
    logic        write;
    logic [14:0] preview;
    logic [1:0]  digit_pos;
    logic        pending;

    hex_entry #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .key_next_n  (key_next_n),
        .key_commit_n(key_commit_n),
        .full        (full),
        .dataIn      (dataIn),
        .write       (write),
        .preview     (preview),
        .digit_pos   (digit_pos),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_preview;
    int unsigned m_pos;
    int unsigned m_data;
    bit          m_pending;
    int unsigned m_exp_wr[$];
    int unsigned got_wr[$];
    bit          cmp_en;
    bit          prev_wr;

    function automatic void m_reset();
        m_preview = 0;
        m_pos     = 3;
        m_data    = 0;
        m_pending = 0;
    endfunction

    function automatic void m_do_write();
        m_exp_wr.push_back(m_preview);
        m_data    = m_preview;
        m_preview = 0;
        m_pos     = 3;
        m_pending = 0;
    endfunction

    // Apply one settled key action: commit beats next; nothing while pending.
    function automatic void m_key(input bit nxt, input bit cmt, input int unsigned v, input bit f);
        int unsigned sh;
        if (m_pending) return;
        if (cmt) begin
            if (f) m_pending = 1;
            else   m_do_write();
        end else if (nxt) begin
            sh        = 4 * m_pos;
            m_preview = ((m_preview & ~(32'hF << sh)) | (v << sh)) & 32'h7FFF;
            m_pos     = (m_pos + 3) % 4;
        end
    endfunction

    // Per-cycle comparison against the model while nothing is in flight.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("preview",   32'(preview),   m_preview);
            check("digit_pos", 32'(digit_pos), m_pos);
            check("pending",   32'(pending),   32'(m_pending));
            check("dataIn",    32'(dataIn),    m_data);
            check("write_idle", 32'(write),    0);
        end
    end

    // Write strobe monitor: never into a full FIFO, never two cycles running.
    always @(negedge clk) begin
        if (write) begin
            check("write_while_full", 32'(full), 0);
            check("write_back2back", 32'(prev_wr), 0);
            got_wr.push_back(32'(dataIn));
        end
        prev_wr = write;
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input bit nxt, input bit cmt, input logic [3:0] v);
        cmp_en = 0;
        @(negedge clk);
        sw = v;
        if (nxt) key_next_n = 1'b0;
        if (cmt) key_commit_n = 1'b0;
        repeat (10) @(negedge clk);
        key_next_n   = 1'b1;
        key_commit_n = 1'b1;
        repeat (10) @(negedge clk);
        m_key(nxt, cmt, 32'(v), full);
        cmp_en = 1;
    endtask

    task automatic glitch_next(input logic [3:0] v);
        @(negedge clk);
        sw = v;
        key_next_n = 1'b0;
        repeat (2) @(negedge clk);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge.
    task automatic reset_pulse();
        cmp_en = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_preview",   32'(preview),   0);
        check("rst_dataIn",    32'(dataIn),    0);
        check("rst_write",     32'(write),     0);
        check("rst_pending",   32'(pending),   0);
        check("rst_digit_pos", 32'(digit_pos), 3);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        cmp_en = 1;
    endtask

    // Drop full while waiting: write must follow one cycle later, for one cycle.
    task automatic release_full();
        cmp_en = 0;
        @(negedge clk);
        full = 1'b0;
        @(posedge clk);
        #1;
        check("lat_write_hi",  32'(write),   1);
        check("lat_dataIn",    32'(dataIn),  m_preview);
        check("lat_pending",   32'(pending), 0);
        @(posedge clk);
        #1;
        check("lat_write_lo",  32'(write),     0);
        check("post_preview",  32'(preview),   0);
        check("post_digit",    32'(digit_pos), 3);
        m_do_write();
        @(negedge clk);
        cmp_en = 1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n        = 1'b1;
        sw           = 4'h0;
        key_next_n   = 1'b1;
        key_commit_n = 1'b1;
        full         = 1'b0;
        cmp_en       = 0;
        prev_wr      = 0;
        m_reset();

        // First press of 0xF keeps only three bits in the top digit.
        reset_pulse();
        press(1, 0, 4'hF);
        check("lit_F_top", 32'(preview), 32'h7000);

        // 5,A,3,C then commit with space.
        reset_pulse();
        press(1, 0, 4'h5);
        press(1, 0, 4'hA);
        press(1, 0, 4'h3);
        press(1, 0, 4'hC);
        check("lit_5A3C", 32'(preview), 32'h5A3C);
        press(0, 1, 4'h0);
        check("lit_5A3C_data", 32'(dataIn), 32'h5A3C);
        check("lit_5A3C_clr",  32'(preview), 0);
        check("lit_5A3C_pos",  32'(digit_pos), 3);
        check("lit_5A3C_nwr",  32'(got_wr.size()), 1);

        // Short glitch on next must not load anything.
        press(1, 0, 4'h1);
        glitch_next(4'h7);
        check("lit_glitch_prev", 32'(preview), 32'h1000);
        check("lit_glitch_pos",  32'(digit_pos), 2);

        // Simultaneous next and commit with sw=9: commit wins.
        press(1, 1, 4'h9);
        check("lit_both_data", 32'(dataIn), 32'h1000);
        check("lit_both_prev", 32'(preview), 0);

        // Commit into a full FIFO, next press while waiting is dropped.
        press(1, 0, 4'h2);
        @(negedge clk);
        full = 1'b1;
        press(0, 1, 4'h0);
        check("lit_pending", 32'(pending), 1);
        repeat (10) @(negedge clk);
        press(1, 0, 4'h5);
        check("lit_wait_prev", 32'(preview), 32'h2000);
        release_full();
        check("lit_wait_data", 32'(dataIn), 32'h2000);

        // Reset while waiting abandons the word.
        press(1, 0, 4'h3);
        @(negedge clk);
        full = 1'b1;
        press(0, 1, 4'h0);
        check("lit_pending2", 32'(pending), 1);
        reset_pulse();
        full = 1'b0;
        repeat (15) @(negedge clk);
        check("lit_abandon_wr", 32'(got_wr.size()), 3);

        // Five presses wrap the cursor and overwrite the top digit.
        press(1, 0, 4'h1);
        press(1, 0, 4'h2);
        press(1, 0, 4'h3);
        press(1, 0, 4'h4);
        press(1, 0, 4'h6);
        check("lit_wrap_prev", 32'(preview), 32'h6234);
        check("lit_wrap_pos",  32'(digit_pos), 2);

        // Key held low through reset release stays silent until re-pressed.
        cmp_en = 0;
        @(negedge clk);
        rst_n      = 1'b0;
        sw         = 4'h5;
        key_next_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("lit_held_prev", 32'(preview), 0);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
        cmp_en = 1;
        press(1, 0, 4'h5);
        check("lit_held_repress", 32'(preview), 32'h5000);

        // Everything the FIFO saw against what the model expected.
        repeat (3) @(negedge clk);
        cmp_en = 0;
        check("wr_count", 32'(got_wr.size()), 32'(m_exp_wr.size()));
        for (int i = 0; i < got_wr.size() && i < m_exp_wr.size(); i++) begin
            check($sformatf("wr_word%0d", i), got_wr[i], m_exp_wr[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_entry.md
HEX_ENTRY -- requirements
Module: hex_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning clocks a raw button level must stay stable to be accepted (10 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sw, input, 4, hex digit value from slide switches.
REQ-005 SHALL have port key_next_n, input, 1, raw active-low pushbutton that loads the current digit.
REQ-006 SHALL have port key_commit_n, input, 1, raw active-low pushbutton that writes the assembled word.
REQ-007 SHALL have port full, input, 1, FIFO full flag.
REQ-008 SHALL have port dataIn, output, 15, word presented to the FIFO write port.
REQ-009 SHALL have port write, output, 1, FIFO write strobe.
REQ-010 SHALL have port preview, output, 15, word under construction, for the four-digit hex display.
REQ-011 SHALL have port digit_pos, output, 2, digit position the next press loads (3 = most significant).
REQ-012 SHALL have port pending, output, 1, high while a commit waits for FIFO space.

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer, then a debouncer; a press event is one clk pulse on a debounced 1->0 transition only.
REQ-014 Debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any change restarts the count.
REQ-015 FSM states SHALL be ENTRY, WAIT_SPACE, WRITE.
REQ-016 In ENTRY, a next event SHALL load sw into preview nibble digit_pos; digit 3 SHALL take sw[2:0], preview[14:12] only, sw[3] ignored.
REQ-017 After each load, digit_pos SHALL decrement 3->2->1->0 and wrap 0->3; wrapping SHALL NOT clear preview, so later loads overwrite.
REQ-018 In ENTRY, a commit event with full=0 SHALL go to WRITE; with full=1 it SHALL go to WAIT_SPACE with pending=1.
REQ-019 WAIT_SPACE SHALL go to WRITE on the first cycle full=0, then clear pending.
REQ-020 WRITE SHALL last exactly one cycle with write=1 and dataIn=preview, then return to ENTRY.
REQ-021 On leaving WRITE, preview SHALL clear to 0 and digit_pos SHALL set to 3.
REQ-022 write SHALL NOT be asserted while full=1, and SHALL never stay high two consecutive cycles.
REQ-023 Next and commit events in WAIT_SPACE or WRITE SHALL be discarded, not queued.
REQ-024 If next and commit events occur in the same ENTRY cycle, commit SHALL win and the digit SHALL NOT load.
REQ-025 dataIn SHALL be registered and hold the last written word between writes.
REQ-026 Latency: commit event to write SHALL be 1 cycle with FIFO space, or 1 cycle after full falls.

Reset
REQ-027 rst_n=0 SHALL immediately force state ENTRY, preview=0, dataIn=0, write=0, pending=0, digit_pos=3, synchronizers=1 (released), debounced levels=1, and debounce counters=0.
REQ-028 Reset mid-WAIT_SPACE or mid-WRITE SHALL abandon the word with no write issued.
REQ-029 A key held low across reset release SHALL NOT produce an event until it is released and pressed again.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, DATA_W=15, DIGITS=4, and the default DEBOUNCE_CYCLES.
REQ-031 A sub-module key_debounce SHALL implement synchronizer, debouncer and falling-edge event, and SHALL be instantiated once per key.

Verification
REQ-032 Directed scenarios (DEBOUNCE_CYCLES=4) SHALL cover:
- Presses with sw=5,A,3,C then commit, full=0 -> one write pulse, dataIn=0x5A3C; then preview=0, digit_pos=3.
- First press with sw=0xF -> preview=0x7000.
- Commit with full=1 held 10 cycles -> pending=1, no write; full falls -> write 1 cycle later; pending clears.
- Key glitch low for 2 cycles -> no event; preview unchanged.
- Next and commit events in the same cycle with sw=9 -> write carries the prior preview; the 9 is not loaded.
- rst_n pulsed low during WAIT_SPACE -> outputs return to reset values; no write after full falls.
- Five presses with sw=1,2,3,4,6 -> digit_pos wraps; preview=0x6234.
